output_display_driver: RTL and testbench

Downstream consumer of the processor's output path. When the processor raises its output strobe, this block captures the 32-bit register value and converts it to decimal with a sequential shift-and-add-3 (double-dabble) engine. It then drives the eight active-low seven-segment displays HEX0..HEX7, with sign, leading-zero blanking and overflow indication. Displays hold the last converted value until the next accepted request.

---
 rtl/output_display_driver.sv | 146 ++++++++++++++
 tb/tb_output_display_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/output_display_driver.sv
// Captures a 32-bit value on start, converts it to BCD with a sequential
// double-dabble engine and drives eight active-low seven-segment displays.
module output_display_driver #(
    parameter bit SIGNED   = 1'b1,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {IDLE, LOAD_SHIFT, UPDATE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [39:0] bcd_q;
    logic [31:0] mag_q;
    logic        neg_q;
    logic [39:0] bcd_adj;
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];
    logic        ovf_d;
    int          top;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = LOAD_SHIFT;
            LOAD_SHIFT: if (cnt_q == 6'd31) state_d = UPDATE;
            UPDATE:     state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Display formatting from the finished BCD result; top is the highest nonzero digit.
    always_comb begin
        top = 0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) top = i;
        end
        ovf_d = (|bcd_q[39:32]) || (neg_q && (top >= 7));
        for (int i = 0; i < 8; i++) begin
            hex_d[i] = SEG_BLANK;
            if (ovf_d) begin
                if (i == 7) hex_d[i] = SEG_E;
            end else if (LZ_BLANK) begin
                if (i <= top)                  hex_d[i] = seg(bcd_q[4*i +: 4]);
                else if (neg_q && i == top + 1) hex_d[i] = SEG_MINUS;
            end else begin
                if (neg_q && i == 7) hex_d[i] = SEG_MINUS;
                else                 hex_d[i] = seg(bcd_q[4*i +: 4]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the BCD and
    // magnitude accumulators are reset too, so an aborted conversion leaves nothing behind.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bcd_q    <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < 8; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bcd_q <= '0;
                    if (start) begin
                        mag_q <= (SIGNED && value[31]) ? -value : value;
                        neg_q <= SIGNED && value[31];
                    end
                end
                LOAD_SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q + 6'd1;
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
                    overflow <= ovf_d;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_output_display_driver.sv
// Bench for output_display_driver: one instance with leading-zero blanking,
// one without, fed the same requests; expected displays written as 8-char strings.
module tb_output_display_driver;

    typedef struct {
        logic [31:0] value;
        logic [63:0] exp_lz1;   // HEX7..HEX0 as characters, LZ_BLANK=1
        logic [63:0] exp_lz0;   // HEX7..HEX0 as characters, LZ_BLANK=0
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;

    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
    logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
    logic [55:0] hex_a, hex_b;

    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[11];
    vec_t sb_q[$];

    assign hex_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign hex_b = {b7, b6, b5, b4, b3, b2, b1, b0};

    always #5 clk = ~clk;

    output_display_driver #(.SIGNED(1'b1), .LZ_BLANK(1'b1)) u_dut (
        .Clock(clk), .reset(rst_n), .start(start), .value(value),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
        .HEX4(a4), .HEX5(a5), .HEX6(a6), .HEX7(a7)
    );

    output_display_driver #(.SIGNED(1'b1), .LZ_BLANK(1'b0)) u_dut_nz (
        .Clock(clk), .reset(rst_n), .start(start), .value(value),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
        .HEX4(b4), .HEX5(b5), .HEX6(b6), .HEX7(b7)
    );

    function automatic logic [6:0] char2seg(input logic [7:0] c);
        case (c)
            "0": char2seg = 7'b1000000;
            "1": char2seg = 7'b1111001;
            "2": char2seg = 7'b0100100;
            "3": char2seg = 7'b0110000;
            "4": char2seg = 7'b0011001;
            "5": char2seg = 7'b0010010;
            "6": char2seg = 7'b0000010;
            "7": char2seg = 7'b1111000;
            "8": char2seg = 7'b0000000;
            "9": char2seg = 7'b0010000;
            "-": char2seg = 7'b0111111;
            "E": char2seg = 7'b0000110;
            " ": char2seg = 7'b1111111;
            default: char2seg = 7'b1010101;
        endcase
    endfunction

    function automatic logic [55:0] exp_hex(input logic [63:0] s);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = char2seg(s[8*i +: 8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request, check its latency, then pop the scoreboard and compare both displays.
    task automatic do_conv(input vec_t v);
        int   cycles;
        vec_t e;
        @(negedge clk);
        value = v.value;
        start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_accept", {63'd0, busy_a}, 64'd1);
        cycles = 0;
        while (!done_a && cycles < 100) begin
            @(posedge clk);
            #1 cycles++;
        end
        check("latency", 64'(cycles), 64'd33);
        e = sb_q.pop_front();
        check("hex_lz1", {8'd0, hex_a}, {8'd0, exp_hex(e.exp_lz1)});
        check("hex_lz0", {8'd0, hex_b}, {8'd0, exp_hex(e.exp_lz0)});
        check("ovf_lz1", {63'd0, ovf_a}, {63'd0, e.exp_ovf});
        check("ovf_lz0", {63'd0, ovf_b}, {63'd0, e.exp_ovf});
        check("busy_at_done", {63'd0, busy_a}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd12345678, "12345678", "12345678", 1'b0};
        vecs[1]  = '{32'd0,        "       0", "00000000", 1'b0};
        vecs[2]  = '{32'hFFFFFFF6, "     -10", "-0000010", 1'b0};
        vecs[3]  = '{32'd100000000, "E       ", "E       ", 1'b1};
        vecs[4]  = '{32'h80000000, "E       ", "E       ", 1'b1};
        vecs[5]  = '{32'hFFFFFF85, "    -123", "-0000123", 1'b0};
        vecs[6]  = '{32'd99999999, "99999999", "99999999", 1'b0};
        vecs[7]  = '{32'hFF676981, "-9999999", "-9999999", 1'b0};
        vecs[8]  = '{32'hFF676980, "E       ", "E       ", 1'b1};
        vecs[9]  = '{32'd5,        "       5", "00000005", 1'b0};
        vecs[10] = '{32'h7FFFFFFF, "E       ", "E       ", 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hex_lz1", {8'd0, hex_a}, {8'd0, {8{7'b1111111}}});
        check("rst_hex_lz0", {8'd0, hex_b}, {8'd0, {8{7'b1111111}}});
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_ovf", {63'd0, ovf_a}, 64'd0);

        for (int i = 0; i < 11; i++) do_conv(vecs[i]);

        // Conversion of 42 with ignored requests at k+5 (shifting) and k+33 (UPDATE).
        @(negedge clk);
        value = 32'd42;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 33; j++) begin
            @(negedge clk);
            if (j == 5 || j == 33) begin
                value = 32'd7;
                start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (j == 33) check("ign_done_at_33", {63'd0, done_a}, 64'd1);
        end
        @(posedge clk);
        #1;
        check("ign_busy_after", {63'd0, busy_a}, 64'd0);
        check("ign_done_after", {63'd0, done_a}, 64'd0);
        check("ign_hex_lz1", {8'd0, hex_a}, {8'd0, exp_hex("      42")});
        check("ign_hex_lz0", {8'd0, hex_b}, {8'd0, exp_hex("00000042")});

        // Leave overflow set, then reset asynchronously in the middle of a conversion.
        do_conv(vecs[3]);
        @(negedge clk);
        value = 32'd55;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_hex_lz1", {8'd0, hex_a}, {8'd0, {8{7'b1111111}}});
        check("async_rst_hex_lz0", {8'd0, hex_b}, {8'd0, {8{7'b1111111}}});
        check("async_rst_busy", {63'd0, busy_a}, 64'd0);
        check("async_rst_ovf", {63'd0, ovf_a}, 64'd0);
        check("async_rst_done", {63'd0, done_a}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_conv(vecs[0]);
        do_conv(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
